// File: rtl/write_through_drain_pkg.sv
// Shared definitions for the write-through drain buffer: drain FSM encoding
// and the width of one buffered entry.
package write_through_drain_pkg;

  typedef enum logic [1:0] {
    D_IDLE = 2'b00,
    D_BUSY = 2'b01
  } drain_state_e;

  function automatic int entry_w(input int addr_w, input int nbytes, input int data_w);
    return addr_w + nbytes + data_w;
  endfunction

endpackage

// File: rtl/write_through_drain_regfile.sv
// Entry storage for the drain buffer: one write port, one combinational
// read port, cleared to zero by the asynchronous reset.
module write_through_drain_regfile #(
  parameter int DEPTH_W = 2,
  parameter int WIDTH   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [DEPTH_W-1:0] waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [DEPTH_W-1:0] raddr,
  output logic [WIDTH-1:0]   rdata
);

  localparam int DEPTH = 2 ** DEPTH_W;

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/write_through_drain.sv
// Write-through buffer: queues front-end word writes and drains them in order
// through a one-outstanding valid/ready requester toward the write channel.
module write_through_drain
  import write_through_drain_pkg::*;
#(
  parameter int FE_ADDR_W = 32,
  parameter int FE_DATA_W = 32,
  parameter int FE_NBYTES = FE_DATA_W / 8,
  parameter int FE_BYTE_W = $clog2(FE_NBYTES),
  parameter int DEPTH_W   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [FE_ADDR_W-FE_BYTE_W-1:0] push_addr,
  input  logic [FE_NBYTES-1:0]           push_wstrb,
  input  logic [FE_DATA_W-1:0]           push_wdata,
  output logic                           full,
  output logic                           empty,
  output logic                           idle,
  output logic [DEPTH_W:0]               level,
  output logic                           overflow,
  output logic                           valid,
  output logic [FE_ADDR_W-FE_BYTE_W-1:0] addr,
  output logic [FE_NBYTES-1:0]           wstrb,
  output logic [FE_DATA_W-1:0]           wdata,
  input  logic                           ready
);

  localparam int AW      = FE_ADDR_W - FE_BYTE_W;
  localparam int DEPTH   = 2 ** DEPTH_W;
  localparam int ENTRY_W = entry_w(AW, FE_NBYTES, FE_DATA_W);

  localparam logic [DEPTH_W:0]   LVL_FULL = (DEPTH_W + 1)'(DEPTH);
  localparam logic [DEPTH_W:0]   LVL_ONE  = (DEPTH_W + 1)'(1);
  localparam logic [DEPTH_W-1:0] PTR_ONE  = DEPTH_W'(1);

  logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_W:0]   level_q, level_d;
  logic               overflow_q, overflow_d;
  drain_state_e       state_q, state_d;

  logic               push_ok;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  // Full is judged on the pre-edge level, so a same-cycle pop never frees a slot.
  assign full    = (level_q == LVL_FULL);
  assign empty   = (level_q == '0);
  assign idle    = empty && (state_q == D_IDLE);
  assign level   = level_q;
  assign overflow = overflow_q;
  assign push_ok = push && !full;
  assign pop     = (state_q == D_BUSY) && ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q | (push && full);
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Head stays presented while busy; it is only popped once the channel completes.
  always_comb begin
    state_d = state_q;
    valid   = 1'b0;
    case (state_q)
      D_IDLE: begin
        valid = !empty;
        if (!empty && ready) state_d = D_BUSY;
      end
      D_BUSY: begin
        if (ready) state_d = D_IDLE;
      end
      default: state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= D_IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

  write_through_drain_regfile #(
    .DEPTH_W (DEPTH_W),
    .WIDTH   (ENTRY_W)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata ({push_addr, push_wstrb, push_wdata}),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  assign {addr, wstrb, wdata} = head;

endmodule

// File: tb/tb_write_through_drain.sv
// Bench for write_through_drain: directed vector tables plus model-checked
// sequences (queue-based reference) for overlap, stall, wrap and reset cases.
module tb_write_through_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic        push;
  logic [29:0] push_addr;
  logic [3:0]  push_wstrb;
  logic [31:0] push_wdata;
  logic        full, empty, idle, overflow, valid, ready;
  logic [2:0]  level;
  logic [29:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;

  int n_cmp = 0;
  int n_bad = 0;

  write_through_drain dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_addr  (push_addr),
    .push_wstrb (push_wstrb),
    .push_wdata (push_wdata),
    .full       (full),
    .empty      (empty),
    .idle       (idle),
    .level      (level),
    .overflow   (overflow),
    .valid      (valid),
    .addr       (addr),
    .wstrb      (wstrb),
    .wdata      (wdata),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        p;
    logic [29:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic        r;
    logic        e_valid;
    logic [2:0]  e_level;
    logic        e_full, e_empty, e_idle, e_ovf, chk_head;
    logic [29:0] e_a;
    logic [31:0] e_d;
  } vec_t;

  vec_t vecs[$];

  // Reference model: pending writes in push order, plus whether the head is in flight.
  logic [65:0] mq[$];
  bit          busy_m;
  bit          ovf_m;

  function automatic vec_t mk(logic p, logic [29:0] a, logic [3:0] s, logic [31:0] d, logic r,
                              logic v, int lv, logic f, logic e, logic idl, logic o,
                              logic ch, logic [29:0] ea, logic [31:0] ed);
    vec_t t;
    t.p = p; t.a = a; t.s = s; t.d = d; t.r = r;
    t.e_valid = v; t.e_level = 3'(lv); t.e_full = f; t.e_empty = e; t.e_idle = idl;
    t.e_ovf = o; t.chk_head = ch; t.e_a = ea; t.e_d = ed;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    push = 1'b0; ready = 1'b0;
    push_addr = '0; push_wstrb = '0; push_wdata = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    mq.delete();
    busy_m = 1'b0;
    ovf_m  = 1'b0;
  endtask

  task automatic apply_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      push = vecs[i].p; push_addr = vecs[i].a; push_wstrb = vecs[i].s;
      push_wdata = vecs[i].d; ready = vecs[i].r;
      @(posedge clk); #1;
      chk($sformatf("%s%0d.valid", tag, i), 96'(valid), 96'(vecs[i].e_valid));
      chk($sformatf("%s%0d.level", tag, i), 96'(level), 96'(vecs[i].e_level));
      chk($sformatf("%s%0d.full", tag, i), 96'(full), 96'(vecs[i].e_full));
      chk($sformatf("%s%0d.empty", tag, i), 96'(empty), 96'(vecs[i].e_empty));
      chk($sformatf("%s%0d.idle", tag, i), 96'(idle), 96'(vecs[i].e_idle));
      chk($sformatf("%s%0d.ovf", tag, i), 96'(overflow), 96'(vecs[i].e_ovf));
      if (vecs[i].chk_head) begin
        chk($sformatf("%s%0d.addr", tag, i), 96'(addr), 96'(vecs[i].e_a));
        chk($sformatf("%s%0d.wdata", tag, i), 96'(wdata), 96'(vecs[i].e_d));
      end
    end
    vecs.delete();
  endtask

  task automatic mstep(input string tag, input logic p, input logic [29:0] a,
                       input logic [3:0] s, input logic [31:0] d, input logic r);
    bit was_full;
    was_full = (mq.size() == 4);
    push = p; push_addr = a; push_wstrb = s; push_wdata = d; ready = r;
    if (busy_m && r) begin
      void'(mq.pop_front());
      busy_m = 1'b0;
    end else if (!busy_m && mq.size() > 0 && r) begin
      busy_m = 1'b1;
    end
    if (p) begin
      if (!was_full) mq.push_back({a, s, d});
      else           ovf_m = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, ".valid"}, 96'(valid), 96'(!busy_m && mq.size() > 0));
    chk({tag, ".level"}, 96'(level), 96'(mq.size()));
    chk({tag, ".full"}, 96'(full), 96'(mq.size() == 4));
    chk({tag, ".empty"}, 96'(empty), 96'(mq.size() == 0));
    chk({tag, ".idle"}, 96'(idle), 96'(mq.size() == 0 && !busy_m));
    chk({tag, ".ovf"}, 96'(overflow), 96'(ovf_m));
    if (mq.size() > 0) chk({tag, ".head"}, 96'({addr, wstrb, wdata}), 96'(mq[0]));
  endtask

  initial begin
    do_reset();
    chk("rst.valid", 96'(valid), 96'(0));
    chk("rst.empty", 96'(empty), 96'(1));
    chk("rst.idle", 96'(idle), 96'(1));
    chk("rst.full", 96'(full), 96'(0));
    chk("rst.level", 96'(level), 96'(0));
    chk("rst.ovf", 96'(overflow), 96'(0));
    chk("rst.head", 96'({addr, wstrb, wdata}), 96'(0));

    // single write: accept, channel busy for 3 cycles, then complete
    vecs.push_back(mk(1, 30'h100, 4'hF, 32'hDEADBEEF, 1, 1, 1, 0, 0, 0, 0, 1, 30'h100, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 30'h100, 32'hDEADBEEF));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 30'h100, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    apply_vecs("t1.");

    // fill past capacity with the channel stalled, then drain 1..4 in order
    for (int k = 1; k <= 5; k++)
      vecs.push_back(mk(1, 30'(k), 4'hF, 32'h11111111 * k, 0, 1, (k > 4) ? 4 : k,
                        k >= 4, 0, 0, k == 5, 1, 30'h1, 32'h11111111));
    for (int k = 1; k <= 4; k++) begin
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 5 - k, k == 1, 0, 0, 1, 1, 30'(k), 32'h11111111 * k));
      vecs.push_back(mk(0, 0, 0, 0, 1, k < 4, 4 - k, 0, k == 4, k == 4, 1, k < 4,
                        30'(k + 1), 32'h11111111 * (k + 1)));
    end
    apply_vecs("t2.");

    // simultaneous push+pop at level 2; push while full and popping is rejected
    do_reset();
    mstep("t4a", 1, 30'hA, 4'h1, 32'hA0A0A0A0, 0);
    mstep("t4b", 1, 30'hB, 4'h3, 32'hB0B0B0B0, 0);
    mstep("t4acc", 0, 0, 0, 0, 1);
    mstep("t4pp", 1, 30'hC, 4'h7, 32'hC0C0C0C0, 1);
    chk("t4.level_same", 96'(level), 96'(2));
    chk("t4.head_b", 96'(addr), 96'(30'hB));
    mstep("t4d", 1, 30'hD, 4'hF, 32'hD0D0D0D0, 0);
    mstep("t4e", 1, 30'hE, 4'hF, 32'hE0E0E0E0, 0);
    mstep("t4acc2", 0, 0, 0, 0, 1);
    mstep("t4fp", 1, 30'hF, 4'hF, 32'hF0F0F0F0, 1);
    chk("t4.level_rej", 96'(level), 96'(3));
    chk("t4.ovf", 96'(overflow), 96'(1));

    // stall: head in flight, channel retrying for 20 cycles
    do_reset();
    mstep("t5p0", 1, 30'h2A, 4'h5, 32'h12345678, 0);
    mstep("t5p1", 1, 30'h2B, 4'hA, 32'h9ABCDEF0, 0);
    mstep("t5acc", 0, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) begin
      mstep("t5st", 0, 0, 0, 0, 0);
      chk("t5.addr", 96'(addr), 96'(30'h2A));
      chk("t5.wdata", 96'(wdata), 96'(32'h12345678));
    end
    mstep("t5pop", 0, 0, 0, 0, 1);
    chk("t5.next", 96'(addr), 96'(30'h2B));

    // wrap: 10 pushes interleaved with drains, model checks order
    do_reset();
    for (int k = 0; k < 30; k++)
      mstep("t3", (k % 3) == 0, 30'(k + 7), 4'(k), 32'hCAFE0000 + k, 1);
    while (mq.size() > 0 || busy_m) mstep("t3dr", 0, 0, 0, 0, 1);

    // randomized traffic
    do_reset();
    for (int k = 0; k < 600; k++)
      mstep("rnd", 1'($urandom_range(0, 2) != 0), 30'($urandom), 4'($urandom),
            32'($urandom), 1'($urandom_range(0, 1)));

    // asynchronous reset while busy with three entries held
    do_reset();
    for (int k = 0; k < 3; k++) mstep("t6p", 1, 30'(k + 1), 4'hF, 32'h60 + k, 0);
    mstep("t6acc", 0, 0, 0, 0, 1);
    ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("t6.valid", 96'(valid), 96'(0));
    chk("t6.empty", 96'(empty), 96'(1));
    chk("t6.idle", 96'(idle), 96'(1));
    chk("t6.level", 96'(level), 96'(0));
    @(posedge clk); #1 reset = 1'b1;
    mq.delete(); busy_m = 1'b0; ovf_m = 1'b0;
    mstep("t6post", 1, 30'h77, 4'h9, 32'h77777777, 0);
    chk("t6.valid_after", 96'(valid), 96'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
